// File: rtl/lisnoc_vc_link_slice.sv
`default_nettype none
// ============================================================================
// Module   : lisnoc_vc_link_slice
// Brief    : VC-aware link register slice with per-VC FIFOs and a round-robin
//            shared output bus. Optional checker: LISNOC_LINK_SLICE_CHECK_EN.
// Revision : 1.0
// ============================================================================
module lisnoc_vc_link_slice #(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int flit_width      = flit_data_width + flit_type_width,
    parameter int vchannels       = 2,
    parameter int depth           = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [flit_width-1:0] in_flit_i,
    input  logic [vchannels-1:0]  in_valid_i,
    output logic [vchannels-1:0]  in_ready_o,
    output logic [flit_width-1:0] out_flit_o,
    output logic [vchannels-1:0]  out_valid_o,
    input  logic [vchannels-1:0]  out_ready_i,
    output logic                  err_o
);

    localparam int c_PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int c_CNT_W = $clog2(depth + 1);
    localparam int c_GNT_W = (vchannels > 1) ? $clog2(vchannels) : 1;

    localparam logic [c_CNT_W-1:0]   c_CNT_FULL = c_CNT_W'(depth);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [vchannels-1:0] c_VLD_ONE  = vchannels'(1);

    logic [flit_width-1:0] mem_q   [vchannels][depth];
    logic [c_PTR_W-1:0]    wptr_q  [vchannels];
    logic [c_PTR_W-1:0]    rptr_q  [vchannels];
    logic [c_CNT_W-1:0]    count_q [vchannels];
    logic [c_CNT_W-1:0]    count_d [vchannels];
    logic [c_GNT_W-1:0]    grant_q;
    logic [c_GNT_W-1:0]    grant_d;

    logic [vchannels-1:0]  w_push_sel;
    logic [vchannels-1:0]  w_push;
    logic [vchannels-1:0]  w_pop;
    logic [vchannels-1:0]  w_empty;
    logic [vchannels-1:0]  w_nonempty_d;
    logic                  w_move;
    logic                  w_found;
    int                    w_scan;

    // Only the lowest-indexed valid bit may push; two's complement isolates it.
    assign w_push_sel = in_valid_i & (~in_valid_i + c_VLD_ONE);
    assign w_push     = w_push_sel & in_ready_o;
    assign w_pop      = out_valid_o & out_ready_i;

    always_comb begin
        for (int v = 0; v < vchannels; v++) begin
            w_empty[v]     = (count_q[v] == '0);
            in_ready_o[v]  = (count_q[v] != c_CNT_FULL);
            out_valid_o[v] = (grant_q == c_GNT_W'(v)) && (count_q[v] != '0);
        end
    end

    always_comb begin
        for (int v = 0; v < vchannels; v++) begin
            count_d[v] = count_q[v];
            if (w_push[v] && !w_pop[v]) begin
                count_d[v] = count_q[v] + c_CNT_ONE;
            end else if (!w_push[v] && w_pop[v]) begin
                count_d[v] = count_q[v] - c_CNT_ONE;
            end
            w_nonempty_d[v] = (count_d[v] != '0);
        end
    end

    assign w_move = (|w_pop) | w_empty[grant_q] | !out_ready_i[grant_q];

    // Scan the other VCs starting after the current grant; stay if none qualifies.
    always_comb begin
        grant_d = grant_q;
        w_found = 1'b0;
        w_scan  = 0;
        if (w_move) begin
            for (int off = 1; off < vchannels; off++) begin
                w_scan = int'(grant_q) + off;
                if (w_scan >= vchannels) begin
                    w_scan = w_scan - vchannels;
                end
                if (!w_found && w_nonempty_d[w_scan[c_GNT_W-1:0]]) begin
                    grant_d = w_scan[c_GNT_W-1:0];
                    w_found = 1'b1;
                end
            end
        end
    end

    assign out_flit_o = w_empty[grant_q] ? '0 : mem_q[grant_q][rptr_q[grant_q]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < vchannels; v++) begin
                count_q[v] <= '0;
                wptr_q[v]  <= '0;
                rptr_q[v]  <= '0;
            end
            grant_q <= '0;
        end else begin
            for (int v = 0; v < vchannels; v++) begin
                count_q[v] <= count_d[v];
                if (w_push[v]) begin
                    wptr_q[v] <= wptr_q[v] + c_PTR_ONE;
                end
                if (w_pop[v]) begin
                    rptr_q[v] <= rptr_q[v] + c_PTR_ONE;
                end
            end
            grant_q <= grant_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int v = 0; v < vchannels; v++) begin
            if (w_push[v]) begin
                mem_q[v][wptr_q[v]] <= in_flit_i;
            end
        end
    end

`ifdef LISNOC_LINK_SLICE_CHECK_EN
    logic                  err_q;
    logic [flit_width-1:0] prev_flit_q;
    logic                  w_multi;
    logic                  w_unstable;

    assign w_multi    = |(in_valid_i & (in_valid_i - c_VLD_ONE));
    assign w_unstable = (|(in_valid_i & ~in_ready_o)) && (in_flit_i != prev_flit_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q       <= 1'b0;
            prev_flit_q <= '0;
        end else begin
            err_q       <= err_q | w_multi | w_unstable;
            prev_flit_q <= in_flit_i;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lisnoc_vc_link_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_lisnoc_vc_link_slice
// Brief    : Directed self-checking bench for lisnoc_vc_link_slice (2 VCs, depth 2).
// Revision : 1.0
// ============================================================================
module tb_lisnoc_vc_link_slice;

    localparam int FW = 34;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [FW-1:0] in_flit_i = '0;
    logic [1:0]    in_valid_i = '0;
    logic [1:0]    in_ready_o;
    logic [FW-1:0] out_flit_o;
    logic [1:0]    out_valid_o;
    logic [1:0]    out_ready_i = '0;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    int            rec_vc[$];
    logic [FW-1:0] rec_flit[$];

    lisnoc_vc_link_slice dut (
        .clk         (clk),
        .rst         (rst),
        .in_flit_i   (in_flit_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_flit_o  (out_flit_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Inputs are set just after a rising edge; transfers are logged at the falling edge.
    task automatic run_cycle();
        @(negedge clk);
        if ((out_valid_o & out_ready_i) != 2'b00) begin
            rec_vc.push_back(out_valid_o[1] ? 1 : 0);
            rec_flit.push_back(out_flit_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i  = 2'($urandom());
            in_flit_i   = FW'({$urandom(), $urandom()});
            out_ready_i = 2'($urandom());
            @(posedge clk);
            #1;
        end
        total++; if (out_valid_o !== 2'b00) begin bad++; $display("FAIL rst_out_valid: got %b want 00", out_valid_o); end
        total++; if (in_ready_o !== 2'b11) begin bad++; $display("FAIL rst_in_ready: got %b want 11", in_ready_o); end
        total++; if (out_flit_o !== '0) begin bad++; $display("FAIL rst_out_flit: got %h want 0", out_flit_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_o); end
        in_valid_i  = 2'b00;
        in_flit_i   = '0;
        out_ready_i = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) run_cycle();
        total++; if (out_valid_o !== 2'b00) begin bad++; $display("FAIL idle_out_valid: got %b want 00", out_valid_o); end
        total++; if (in_ready_o !== 2'b11) begin bad++; $display("FAIL idle_in_ready: got %b want 11", in_ready_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL idle_err: got %b want 0", err_o); end
    endtask

    task automatic test_streaming();
        out_ready_i = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            in_valid_i = 2'b01;
            in_flit_i  = FW'(k);
            run_cycle();
            total++; if (out_valid_o !== 2'b01) begin bad++; $display("FAIL stream_valid_%0d: got %b want 01", k, out_valid_o); end
            total++; if (out_flit_o !== FW'(k)) begin bad++; $display("FAIL stream_flit_%0d: got %h want %h", k, out_flit_o, FW'(k)); end
        end
        in_valid_i = 2'b00;
        run_cycle();
        total++; if (out_valid_o !== 2'b00) begin bad++; $display("FAIL stream_end: got %b want 00", out_valid_o); end
    endtask

    task automatic test_full();
        logic [FW-1:0] exp_f[3];
        exp_f[0] = FW'(34'hA); exp_f[1] = FW'(34'hB); exp_f[2] = FW'(34'hC);
        rec_vc.delete(); rec_flit.delete();
        out_ready_i = 2'b00;
        in_valid_i  = 2'b10;
        in_flit_i   = exp_f[0];
        run_cycle();
        total++; if (in_ready_o !== 2'b11) begin bad++; $display("FAIL full_one: got %b want 11", in_ready_o); end
        in_flit_i = exp_f[1];
        run_cycle();
        total++; if (in_ready_o !== 2'b01) begin bad++; $display("FAIL full_two: got %b want 01", in_ready_o); end
        total++; if (out_valid_o !== 2'b10) begin bad++; $display("FAIL full_valid: got %b want 10", out_valid_o); end
        in_flit_i = exp_f[2];
        run_cycle();
        run_cycle();
        total++; if (in_ready_o !== 2'b01) begin bad++; $display("FAIL full_hold_ready: got %b want 01", in_ready_o); end
        total++; if (out_flit_o !== exp_f[0]) begin bad++; $display("FAIL full_hold_head: got %h want %h", out_flit_o, exp_f[0]); end
        out_ready_i = 2'b11;
        run_cycle();
        total++; if (in_ready_o !== 2'b11) begin bad++; $display("FAIL full_pop_ready: got %b want 11", in_ready_o); end
        total++; if (out_flit_o !== exp_f[1]) begin bad++; $display("FAIL full_pop_head: got %h want %h", out_flit_o, exp_f[1]); end
        run_cycle();
        total++; if (out_flit_o !== exp_f[2]) begin bad++; $display("FAIL full_c_head: got %h want %h", out_flit_o, exp_f[2]); end
        in_valid_i = 2'b00;
        run_cycle();
        total++; if (out_valid_o !== 2'b00) begin bad++; $display("FAIL full_drained: got %b want 00", out_valid_o); end
        total++; if (rec_flit.size() !== 3) begin bad++; $display("FAIL full_count: got %0d want 3", rec_flit.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [FW-1:0] g;
            g = (i < rec_flit.size()) ? rec_flit[i] : '1;
            total++; if (g !== exp_f[i]) begin bad++; $display("FAIL full_order_%0d: got %h want %h", i, g, exp_f[i]); end
        end
    endtask

    task automatic test_isolation();
        int cyc;
        rec_vc.delete(); rec_flit.delete();
        out_ready_i = 2'b10;
        in_valid_i  = 2'b01; in_flit_i = FW'(34'h10); run_cycle();
        in_flit_i   = FW'(34'h11); run_cycle();
        in_valid_i  = 2'b10; in_flit_i = FW'(34'h20); run_cycle();
        in_flit_i   = FW'(34'h21); run_cycle();
        in_valid_i  = 2'b00;
        cyc = 0;
        while (rec_flit.size() < 2 && cyc < 10) begin run_cycle(); cyc++; end
        total++; if (rec_flit.size() !== 2) begin bad++; $display("FAIL iso_vc1_count: got %0d want 2", rec_flit.size()); end
        total++; if (in_ready_o[0] !== 1'b0) begin bad++; $display("FAIL iso_vc0_full: got %b want 0", in_ready_o[0]); end
        for (int i = 0; i < 2; i++) begin
            int gv; logic [FW-1:0] gf;
            gv = (i < rec_vc.size()) ? rec_vc[i] : -1;
            gf = (i < rec_flit.size()) ? rec_flit[i] : '1;
            total++; if (gv !== 1 || gf !== FW'(34'h20 + i)) begin bad++; $display("FAIL iso_vc1_%0d: got vc%0d %h want vc1 %h", i, gv, gf, FW'(34'h20 + i)); end
        end
        rec_vc.delete(); rec_flit.delete();
        out_ready_i = 2'b11;
        cyc = 0;
        while (rec_flit.size() < 2 && cyc < 10) begin run_cycle(); cyc++; end
        total++; if (rec_flit.size() !== 2) begin bad++; $display("FAIL iso_vc0_count: got %0d want 2", rec_flit.size()); end
        for (int i = 0; i < 2; i++) begin
            int gv; logic [FW-1:0] gf;
            gv = (i < rec_vc.size()) ? rec_vc[i] : -1;
            gf = (i < rec_flit.size()) ? rec_flit[i] : '1;
            total++; if (gv !== 0 || gf !== FW'(34'h10 + i)) begin bad++; $display("FAIL iso_vc0_%0d: got vc%0d %h want vc0 %h", i, gv, gf, FW'(34'h10 + i)); end
        end
    endtask

    task automatic test_fairness();
        int            exp_vc[4];
        logic [FW-1:0] exp_f[4];
        exp_vc[0] = 0; exp_vc[1] = 1; exp_vc[2] = 0; exp_vc[3] = 1;
        exp_f[0] = FW'(34'h30); exp_f[1] = FW'(34'h40); exp_f[2] = FW'(34'h31); exp_f[3] = FW'(34'h41);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rec_vc.delete(); rec_flit.delete();
        out_ready_i = 2'b00;
        in_valid_i  = 2'b01; in_flit_i = exp_f[0]; run_cycle();
        in_flit_i   = exp_f[2]; run_cycle();
        in_valid_i  = 2'b10; in_flit_i = exp_f[1]; run_cycle();
        in_flit_i   = exp_f[3]; run_cycle();
        in_valid_i  = 2'b00;
        total++; if (in_ready_o !== 2'b00) begin bad++; $display("FAIL fair_both_full: got %b want 00", in_ready_o); end
        total++; if (out_valid_o !== 2'b01) begin bad++; $display("FAIL fair_start_vc: got %b want 01", out_valid_o); end
        out_ready_i = 2'b11;
        for (int i = 0; i < 4; i++) run_cycle();
        total++; if (out_valid_o !== 2'b00) begin bad++; $display("FAIL fair_drain: got %b want 00", out_valid_o); end
        for (int i = 0; i < 4; i++) begin
            int gv; logic [FW-1:0] gf;
            gv = (i < rec_vc.size()) ? rec_vc[i] : -1;
            gf = (i < rec_flit.size()) ? rec_flit[i] : '1;
            total++; if (gv !== exp_vc[i] || gf !== exp_f[i]) begin bad++; $display("FAIL fair_seq_%0d: got vc%0d %h want vc%0d %h", i, gv, gf, exp_vc[i], exp_f[i]); end
        end
    endtask

    task automatic test_reset_mid();
        out_ready_i = 2'b00;
        in_valid_i  = 2'b01; in_flit_i = FW'(34'h50); run_cycle();
        in_flit_i   = FW'(34'h51); run_cycle();
        in_valid_i  = 2'b00;
        total++; if (in_ready_o !== 2'b10) begin bad++; $display("FAIL mid_full: got %b want 10", in_ready_o); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (out_valid_o !== 2'b00) begin bad++; $display("FAIL mid_async_valid: got %b want 00", out_valid_o); end
        total++; if (in_ready_o !== 2'b11) begin bad++; $display("FAIL mid_async_ready: got %b want 11", in_ready_o); end
        total++; if (out_flit_o !== '0) begin bad++; $display("FAIL mid_async_flit: got %h want 0", out_flit_o); end
        @(negedge clk);
        rst = 1'b1;
        run_cycle();
        total++; if (out_valid_o !== 2'b00) begin bad++; $display("FAIL mid_empty: got %b want 00", out_valid_o); end
        in_valid_i = 2'b01; in_flit_i = FW'(34'h55); run_cycle();
        in_valid_i = 2'b00;
        total++; if (out_flit_o !== FW'(34'h55)) begin bad++; $display("FAIL mid_new_head: got %h want 55", out_flit_o); end
        out_ready_i = 2'b11; run_cycle();
        out_ready_i = 2'b00;
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL mid_err_clear: got %b want 0", err_o); end
        in_valid_i = 2'b11; in_flit_i = FW'(34'h66); run_cycle();
        in_valid_i = 2'b00;
        total++; if (out_valid_o !== 2'b01) begin bad++; $display("FAIL multi_lowest_vc: got %b want 01", out_valid_o); end
        total++; if (out_flit_o !== FW'(34'h66)) begin bad++; $display("FAIL multi_flit: got %h want 66", out_flit_o); end
        total++; if (in_ready_o !== 2'b11) begin bad++; $display("FAIL multi_ready: got %b want 11", in_ready_o); end
`ifdef LISNOC_LINK_SLICE_CHECK_EN
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err_o); end
        for (int i = 0; i < 3; i++) run_cycle();
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_o); end
        rst = 1'b0;
        #1;
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_reset: got %b want 0", err_o); end
        @(negedge clk);
        rst = 1'b1;
`else
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_tied: got %b want 0", err_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_full();
        test_isolation();
        test_fairness();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
